rr_mux_arb8: RTL
================

# rr_mux_arb8

Round-robin arbiter that shares one 8-bit, 8:1 data mux between eight requesters and presents the winning word on a single valid/ready output port. It holds one registered output word. It sits between eight independent byte producers and one downstream consumer. A new word is captured every cycle the output slot is free or being drained, so sustained throughput is one word per clock.

## Interface
- RESET_PTR, 0: requester index (0..7) holding top priority after reset.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  8  request, bit k = requester k has a word on din slice k
- din  in  64  data; din[8k+7:8k] is requester k's word
- ack  out  8  one-hot, combinational; bit k high = requester k's word is captured at this clock edge
- out_valid  out  1  out_data holds an unconsumed word
- out_data  out  8  registered captured word
- sel  out  3  index of the requester that supplied out_data
- out_ready  in  1  downstream accepts out_data this edge
- lock  in  8  per-requester grant lock; present only with ARB_LOCK_EN

## Operation
- State: IDLE (slot empty) and BUSY (slot full). State, ptr[2:0], out_data and sel are registers.
- Capture opportunity: `cap = (state==IDLE) | out_ready`.
- Winner: the first k with req[k]=1, searching ptr, ptr+1, …, ptr+7 mod 8.
- If cap is high and req is nonzero:
  - ack = onehot(winner).
  - At the edge: out_data <= din slice of winner, sel <= winner, ptr <= winner+1 mod 8, state <= BUSY.
- If cap is high and req is zero: ack = 0. At the edge, state <= IDLE, and out_data and sel hold.
- If cap is low (BUSY and !out_ready): ack = 0 and all registers hold.
- out_valid = (state==BUSY).
- Requester contract:
  - Hold req and din stable until ack[k] is seen high at an edge.
  - Dropping req before ack withdraws the request; this is legal and no word is lost.
  - A requester may re-request in the cycle after its ack. It then has lowest priority.
- Reset values: state=IDLE, ptr=RESET_PTR, out_valid=0, out_data=8'h00, sel=3'd0, ack=8'h00.
- Reset mid-operation discards any pending word and immediately deasserts out_valid.

## Timing
- Latency: req is sampled and ack is high in cycle N. out_valid and out_data are valid in cycle N+1.
- Back-to-back operation: while BUSY with out_ready=1 and req nonzero, the handshake and the next capture occur on the same edge. out_valid stays high and no bubble is inserted.
- ack depends combinationally on req, state, ptr and out_ready. There is no path from din to ack.
- out_data and sel are stable for as long as out_valid=1 and out_ready=0.
- ptr wrap-around: 7+1 → 0.

## Configuration
- ARB_LOCK_EN defined:
  - The lock port exists.
  - If BUSY, cap is high, and both lock[sel] and req[sel] are 1, the winner is sel regardless of ptr, and ptr does not advance.
  - When lock[sel] drops, normal round-robin resumes from the unchanged ptr.
- ARB_LOCK_EN undefined: the lock port is absent and arbitration is pure round-robin.

## Structure
- Package rr_arb_pkg holds:
  - NREQ=8, SELW=3, DW=8
  - state typedef {IDLE=1'b0, BUSY=1'b1}
  - rotate-left helper function for the priority search
- Sub-module: one instance of the existing mux8t1, with sel driven by the combinational winner index and inputs driven by the din slices. Its output feeds the out_data register D-input.
- Winner search is done inside the block as rotate, find-first, then add ptr.

## Test plan
- Reset: hold rst_n=0 with req=8'hFF → out_valid=0, out_data=8'h00, sel=0, ack=8'h00. After release, the first grant goes to RESET_PTR.
- Single requester: req=8'h04, din[23:16]=8'hA5, state IDLE → ack=8'h04 this cycle. Next cycle: out_valid=1, out_data=8'hA5, sel=2.
- Fairness: req=8'hFF held, out_ready=1, RESET_PTR=0 → sel sequence 0,1,…,7,0 on consecutive cycles, with ack rotating one-hot each cycle.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with req=8'h10 → ack=0 and out_data/sel unchanged throughout. When out_ready rises, ack=8'h10 and requester 4 is captured on the same edge.
- Wrap: after a grant to 6 (ptr=7), req=8'h41 → winner 0 first, then 6.
- Lock (ARB_LOCK_EN): req=8'h03, lock=8'h01, out_ready=1 → sel=0 on three consecutive words. Then lock=0 → next winner 1.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants, state type and priority-rotation helper for the round-robin mux arbiter.
package rr_arb_pkg;

  localparam int unsigned NREQ = 8;
  localparam int unsigned SELW = 3;
  localparam int unsigned DW   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Bit j of the result is v[(j - amt) mod NREQ]; rotating by -ptr puts req[ptr] at bit 0.
  function automatic logic [NREQ-1:0] rotl(input logic [NREQ-1:0] v,
                                           input logic [SELW-1:0] amt);
    logic [NREQ-1:0] r;
    logic [SELW-1:0] src;
    r = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      src  = SELW'(j) - amt;
      r[j] = v[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/mux8t1.sv
// Eight-way byte multiplexer: picks one DW-bit slice of din by sel.
module mux8t1
  import rr_arb_pkg::*;
(
  input  logic [NREQ*DW-1:0] din,
  input  logic [SELW-1:0]    sel,
  output logic [DW-1:0]      dout
);

  always_comb begin
    dout = '0;
    unique case (sel)
      3'd0: dout = din[0*DW +: DW];
      3'd1: dout = din[1*DW +: DW];
      3'd2: dout = din[2*DW +: DW];
      3'd3: dout = din[3*DW +: DW];
      3'd4: dout = din[4*DW +: DW];
      3'd5: dout = din[5*DW +: DW];
      3'd6: dout = din[6*DW +: DW];
      3'd7: dout = din[7*DW +: DW];
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arb8.sv
// Round-robin arbiter sharing one 8:1 byte mux among eight requesters, one registered output slot.
// Optional grant lock on the current owner is enabled by defining ARB_LOCK_EN.
module rr_mux_arb8
  import rr_arb_pkg::*;
#(
  parameter int unsigned RESET_PTR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  output logic [NREQ-1:0]      ack,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [SELW-1:0]      sel,
  input  logic                 out_ready
`ifdef ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]      lock
`endif
);

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   mux_out;

  logic            cap;
  logic            any_req;
  logic            grant;
  logic            hold_ptr;
  logic [NREQ-1:0] rot;
  logic [SELW-1:0] ff_idx;
  logic [SELW-1:0] rr_win;
  logic [SELW-1:0] win;

  assign cap     = (state_q == IDLE) | out_ready;
  assign any_req = |req;
  assign grant   = cap & any_req;

  // Rotate so the requester at ptr sits at bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    rot    = rotl(req, SELW'(0) - ptr_q);
    ff_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        ff_idx = SELW'(i);
      end
    end
    rr_win = ff_idx + ptr_q;
  end

`ifdef ARB_LOCK_EN
  // A locked owner that keeps requesting is re-granted without moving the round-robin pointer.
  assign hold_ptr = (state_q == BUSY) & lock[sel_q] & req[sel_q];
`else
  assign hold_ptr = 1'b0;
`endif

  assign win = hold_ptr ? sel_q : rr_win;

  mux8t1 u_mux (
    .din  (din),
    .sel  (win),
    .dout (mux_out)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cap) begin
      state_d = any_req ? BUSY : IDLE;
    end
  end

  // Output logic; ack is forced low while reset is asserted.
  always_comb begin
    ack       = '0;
    out_valid = (state_q == BUSY);
    if (grant && rst_n) begin
      ack[win] = 1'b1;
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    sel_d  = sel_q;
    data_d = data_q;
    if (grant) begin
      data_d = mux_out;
      sel_d  = win;
      if (!hold_ptr) begin
        ptr_d = win + SELW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= SELW'(RESET_PTR);
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      sel_q  <= sel_d;
      data_q <= data_d;
    end
  end

  assign out_data = data_q;
  assign sel      = sel_q;

endmodule
